// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master that feeds the SPI slave/RAM wrapper.
package spi_pkg;
  localparam logic [1:0] OP_WR_ADDR = 2'b00;
  localparam logic [1:0] OP_WR_DATA = 2'b01;
  localparam logic [1:0] OP_RD_ADDR = 2'b10;
  localparam logic [1:0] OP_RD_DATA = 2'b11;

  localparam int FRAME_BITS = 10;
  localparam int DATA_BITS  = 8;
  localparam int CNT_W      = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_WAIT_RD,
    ST_CAPTURE,
    ST_GAP
  } state_e;

  typedef struct packed {
    logic [1:0]           op;
    logic [DATA_BITS-1:0] data;
  } cmd_t;
endpackage

// File: rtl/spi_shreg.sv
// Parallel-load MOSI shift register (MSB first) plus MISO shift-in path.
module spi_shreg
  import spi_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_data,
  input  logic                  shift,
  output logic                  mosi_bit,
  input  logic                  cap_en,
  input  logic                  miso,
  output logic [DATA_BITS-1:0]  rx_next
);
  logic [FRAME_BITS-1:0] tx;
  logic [DATA_BITS-2:0]  rx;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx <= '0;
    end else if (load) begin
      tx <= load_data;
    end else if (shift) begin
      tx <= {tx[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Only 7 bits are stored; the 8th arrives on the final capture edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx <= '0;
    end else if (cap_en) begin
      rx <= rx_next[DATA_BITS-2:0];
    end
  end

  assign mosi_bit = tx[FRAME_BITS-1];
  assign rx_next  = {rx, miso};
endmodule

// File: rtl/spi_master_ctrl.sv
// SPI master: turns single host commands into wrapper frames, returns read bytes.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int GAP        = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [1:0]           cmd_op,
  input  logic [DATA_BITS-1:0] cmd_data,
  output logic                 rsp_valid,
  output logic [DATA_BITS-1:0] rsp_data,
  output logic                 busy,
  output logic                 SS_n,
  output logic                 MOSI,
  input  logic                 MISO
);
  state_e             state, nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [1:0]         op_q;
  logic               load, shift, cap_en, cap_done;
  logic               ss_n_d, mosi_d, tx_msb;
  logic [DATA_BITS-1:0] rx_next;
  cmd_t               cmd;

  assign cmd = '{op: cmd_op, data: cmd_data};

  function automatic logic [CNT_W-1:0] reload(input state_e s);
    case (s)
      ST_START:   reload = CNT_W'(1);
      ST_SHIFT:   reload = CNT_W'(FRAME_BITS - 1);
      ST_WAIT_RD: reload = CNT_W'(RD_LATENCY - 1);
      ST_CAPTURE: reload = CNT_W'(DATA_BITS - 1);
      ST_GAP:     reload = CNT_W'(GAP - 1);
      default:    reload = '0;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      op_q  <= OP_WR_ADDR;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
      if (load) op_q <= cmd.op;
    end
  end

  always_comb begin
    nxt     = state;
    cnt_nxt = (cnt != '0) ? cnt - CNT_W'(1) : cnt;
    case (state)
      ST_IDLE:    if (cmd_valid) nxt = ST_START;
      ST_START:   if (cnt == '0) nxt = ST_SHIFT;
      ST_SHIFT:   if (cnt == '0) nxt = (op_q == OP_RD_DATA) ? ST_WAIT_RD : ST_GAP;
      ST_WAIT_RD: if (cnt == '0) nxt = ST_CAPTURE;
      ST_CAPTURE: if (cnt == '0) nxt = ST_GAP;
      ST_GAP:     if (cnt == '0) nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
    if (nxt != state) cnt_nxt = reload(nxt);
  end

  // Pin values are computed for the state being entered so SS_n/MOSI stay registered.
  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = ~cmd_ready;
    load      = cmd_ready & cmd_valid;
    shift     = (nxt == ST_SHIFT);
    cap_en    = (state == ST_CAPTURE);
    cap_done  = cap_en & (cnt == '0);
    ss_n_d    = 1'b1;
    mosi_d    = 1'b0;
    case (nxt)
      ST_START: begin
        ss_n_d = 1'b0;
        mosi_d = (state == ST_IDLE) ? cmd.op[1] : op_q[1];
      end
      ST_SHIFT: begin
        ss_n_d = 1'b0;
        mosi_d = tx_msb;
      end
      ST_WAIT_RD, ST_CAPTURE: ss_n_d = 1'b0;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      SS_n      <= 1'b1;
      MOSI      <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      SS_n      <= ss_n_d;
      MOSI      <= mosi_d;
      rsp_valid <= cap_done;
      if (cap_done) rsp_data <= rx_next;
    end
  end

  spi_shreg u_shreg (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .load_data(cmd),
    .shift    (shift),
    .mosi_bit (tx_msb),
    .cap_en   (cap_en),
    .miso     (MISO),
    .rx_next  (rx_next)
  );
endmodule
